// File: rtl/tc_fast_ram_arbiter_if.sv
// Bus bundle between two single-word requesters, the arbiter and one TC_FastRam.
// The lock0/lock1 pins exist only when TC_FASTRAM_ARB_LOCK_EN is defined.
interface tc_fast_ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
`ifdef TC_FASTRAM_ARB_LOCK_EN
  logic          lock0;
  logic          lock1;
`endif
  logic          ram_load;
  logic          ram_save;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out;

  modport slave (
`ifdef TC_FASTRAM_ARB_LOCK_EN
    input  lock0, lock1,
`endif
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    output ack0, ack1, rdata0, rdata1, ram_load, ram_save, ram_address, ram_in
  );

  modport master (
`ifdef TC_FASTRAM_ARB_LOCK_EN
    output lock0, lock1,
`endif
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    input  ack0, ack1, rdata0, rdata1, ram_load, ram_save, ram_address, ram_in
  );
endinterface

// File: rtl/tc_fast_ram_arbiter.sv
// Round-robin arbiter sharing one TC_FastRam between two req/ack requesters.
// Define TC_FASTRAM_ARB_LOCK_EN to add lock0/lock1 bus-ownership inputs.
module tc_fast_ram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tc_fast_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          blk0, blk1;
  logic          elig0, elig1;

  always_comb begin
    sel_we    = grant_q ? bus.we1    : bus.we0;
    sel_addr  = grant_q ? bus.addr1  : bus.addr0;
    sel_wdata = grant_q ? bus.wdata1 : bus.wdata0;
  end

`ifdef TC_FASTRAM_ARB_LOCK_EN
  logic own_vld_q, own_vld_d;
  logic own_q, own_d;

  // A port is blocked only while the other port owns the bus and still holds its lock.
  always_comb begin
    blk0 = own_vld_q &&  own_q && bus.lock1;
    blk1 = own_vld_q && !own_q && bus.lock0;
  end

  always_comb begin
    own_vld_d = own_vld_q;
    own_d     = own_q;
    if (own_vld_q && !(own_q ? bus.lock1 : bus.lock0)) begin
      own_vld_d = 1'b0;
    end
    if (state_q == ACCESS && (grant_q ? bus.lock1 : bus.lock0)) begin
      own_vld_d = 1'b1;
      own_d     = grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_vld_q <= 1'b0;
      own_q     <= 1'b0;
    end else begin
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
    end
  end
`else
  always_comb begin
    blk0 = 1'b0;
    blk1 = 1'b0;
  end
`endif

  always_comb begin
    elig0 = bus.req0 && !blk0;
    elig1 = bus.req1 && !blk1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (elig0 && elig1) begin
          grant_d = ~last_q;
          state_d = ACCESS;
        end else if (elig0) begin
          grant_d = 1'b0;
          state_d = ACCESS;
        end else if (elig1) begin
          grant_d = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = DONE;
      DONE: begin
        // Only the port not just served may chain straight into ACCESS.
        if (grant_q ? elig0 : elig1) begin
          grant_d = ~grant_q;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (state_q == ACCESS) begin
      last_d = grant_q;
      ack0_d = !grant_q;
      ack1_d = grant_q;
      if (!sel_we) begin
        if (grant_q) rdata1_d = bus.ram_out;
        else         rdata0_d = bus.ram_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes are gated by rst so a reset landing mid-ACCESS never commits a write.
  always_comb begin
    bus.ram_load    = 1'b0;
    bus.ram_save    = 1'b0;
    bus.ram_address = '0;
    bus.ram_in      = '0;
    if (state_q == ACCESS) begin
      bus.ram_address = sel_addr;
      bus.ram_in      = sel_wdata;
      bus.ram_save    = sel_we  && !rst;
      bus.ram_load    = !sel_we && !rst;
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_tc_fast_ram_arbiter.sv
// Directed bench for tc_fast_ram_arbiter with a behavioural TC_FastRam model.
// Covers the TC_FASTRAM_ARB_LOCK_EN variant when that macro is defined.
module tb_tc_fast_ram_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ack_log[$];
  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  tc_fast_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  tc_fast_ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: combinational read, write on the rising edge while save is high.
  assign bus.ram_out = mem[bus.ram_address[7:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.ram_save) begin
      mem[bus.ram_address[7:0]] <= bus.ram_in;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ack0 === 1'b1) ack_log.push_back(0);
    if (bus.ack1 === 1'b1) ack_log.push_back(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at posedge+1, returns at posedge+1 after the ack cycle with req dropped.
  task automatic do_req(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                        output int lat, output int ack_cyc, output int nsave,
                        output int nload, output logic [AW-1:0] ram_a);
    bit got;
    got = 1'b0; lat = 0; ack_cyc = -1; nsave = 0; nload = 0; ram_a = '0; rdata = '0;
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
    while (!got && lat < 20) begin
      @(negedge clk);
      if (bus.ram_save === 1'b1) nsave++;
      if (bus.ram_load === 1'b1) nload++;
      if (bus.ram_save === 1'b1 || bus.ram_load === 1'b1) ram_a = bus.ram_address;
      if ((port ? bus.ack1 : bus.ack0) === 1'b1) begin
        got = 1'b1;
        ack_cyc = cyc;
        rdata = port ? bus.rdata1 : bus.rdata0;
      end else begin
        lat++;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL timeout port%0d: no ack after %0d cycles, required within 20", port, lat);
    end
    @(posedge clk);
    #1;
    if (port) bus.req1 = 1'b0;
    else      bus.req0 = 1'b0;
  endtask

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [DW-1:0] rd_a [2];
    logic [AW-1:0] ra_a [2];
    int lat_a [2];
    int ac_a  [2];
    int ns_a  [2];
    int nl_a  [2];
    int base;
    int prev;
    int exp_seq [4];

    // Writes expect the port's held rdata from its previous read.
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001};
    vecs[2] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[7] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h0000};
    vecs[8] = '{1'b0, 1'b1, 16'h00FF, 16'h8001, 16'hFFFF};
    vecs[9] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h8001};

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
`ifdef TC_FASTRAM_ARB_LOCK_EN
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
`endif

    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("reset ack0", bus.ack0, 0);
    chk("reset ack1", bus.ack1, 0);
    chk("reset rdata0", bus.rdata0, 0);
    chk("reset rdata1", bus.rdata1, 0);
    chk("reset ram_load", bus.ram_load, 0);
    chk("reset ram_save", bus.ram_save, 0);
    chk("reset ram_address", bus.ram_address, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_clr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
      chk($sformatf("v%0d rdata", i), rd_a[0], vecs[i].exp_rdata);
      chk($sformatf("v%0d latency", i), lat_a[0], 2);
      chk($sformatf("v%0d save cycles", i), ns_a[0], vecs[i].we ? 1 : 0);
      chk($sformatf("v%0d load cycles", i), nl_a[0], vecs[i].we ? 0 : 1);
      chk($sformatf("v%0d ram_address", i), ra_a[0], vecs[i].addr);
    end

    // Simultaneous writes right after reset: first tie goes to port 0.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      do_req(1'b0, 1'b1, 16'h0001, 16'hAAAA, rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
      do_req(1'b1, 1'b1, 16'h0002, 16'h5555, rd_a[1], lat_a[1], ac_a[1], ns_a[1], nl_a[1], ra_a[1]);
    join
    chk("tie p0 latency", lat_a[0], 2);
    chk("tie p1 latency", lat_a[1], 4);
    chk("tie ack spacing", ac_a[1] - ac_a[0], 2);
    do_req(1'b0, 1'b0, 16'h0001, '0, rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
    chk("tie readback p0", rd_a[0], 16'hAAAA);
    do_req(1'b1, 1'b0, 16'h0002, '0, rd_a[1], lat_a[1], ac_a[1], ns_a[1], nl_a[1], ra_a[1]);
    chk("tie readback p1", rd_a[1], 16'h5555);

    // Continuous reads from both ports must alternate, port 0 first (last grant was port 1).
    base = ack_log.size();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          do_req(1'b0, 1'b0, 16'h0001, '0, rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
          chk($sformatf("alt p0 rd%0d", i), rd_a[0], 16'hAAAA);
          chk($sformatf("alt p0 wait%0d<=4", i), lat_a[0] <= 4, 1);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          do_req(1'b1, 1'b0, 16'h0002, '0, rd_a[1], lat_a[1], ac_a[1], ns_a[1], nl_a[1], ra_a[1]);
          chk($sformatf("alt p1 rd%0d", j), rd_a[1], 16'h5555);
          chk($sformatf("alt p1 wait%0d<=4", j), lat_a[1] <= 4, 1);
        end
      end
    join
    chk("alt ack count", ack_log.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("alt order%0d", k),
          (base + k < ack_log.size()) ? ack_log[base + k] : -1, k % 2);
    end

    // Reset during the ACCESS cycle of a write: no strobe, no ack, data not committed.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0003; bus.wdata0 = 16'h1234;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst-in-access ram_save", bus.ram_save, 0);
    chk("rst-in-access ram_load", bus.ram_load, 0);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("rst-in-access ack0", bus.ack0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst ack0", bus.ack0, 0);
    @(posedge clk);
    #1;
    do_req(1'b0, 1'b0, 16'h0003, '0, rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
    chk("rst-in-access readback", rd_a[0], 16'h0000);

    // Same-port back-to-back writes: one ack per 3 cycles.
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b1, 16'h0010 + 16'(i), 16'hC000 + 16'(i),
             rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
      chk($sformatf("b2b latency%0d", i), lat_a[0], 2);
      if (i > 0) chk($sformatf("b2b spacing%0d", i), ac_a[0] - prev, 3);
      prev = ac_a[0];
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b0, 16'h0010 + 16'(i), '0, rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
      chk($sformatf("b2b readback%0d", i), rd_a[0], 16'hC000 + 16'(i));
    end

    // Port 0 issues three writes (locked when the lock feature exists); port 1 joins a cycle later.
    base = ack_log.size();
    fork
      begin
`ifdef TC_FASTRAM_ARB_LOCK_EN
        bus.lock0 = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
          do_req(1'b0, 1'b1, 16'h0030 + 16'(i), 16'h7000 + 16'(i),
                 rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
        end
`ifdef TC_FASTRAM_ARB_LOCK_EN
        bus.lock0 = 1'b0;
`endif
      end
      begin
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b1, 16'h0040, 16'h9999, rd_a[1], lat_a[1], ac_a[1], ns_a[1], nl_a[1], ra_a[1]);
      end
    join
`ifdef TC_FASTRAM_ARB_LOCK_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 0};
`endif
    chk("lock ack count", ack_log.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lock order%0d", k),
          (base + k < ack_log.size()) ? ack_log[base + k] : -1, exp_seq[k]);
    end
    do_req(1'b1, 1'b0, 16'h0040, '0, rd_a[1], lat_a[1], ac_a[1], ns_a[1], nl_a[1], ra_a[1]);
    chk("lock p1 readback", rd_a[1], 16'h9999);
    do_req(1'b0, 1'b0, 16'h0032, '0, rd_a[0], lat_a[0], ac_a[0], ns_a[0], nl_a[0], ra_a[0]);
    chk("lock p0 readback", rd_a[0], 16'h7002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
